tt_sweep_checker: RTL

- Self-checking characterisation stage that wraps a 3-input truth-table logic gate module (e.g. a gate with truth table 0x5B).
- Drives the gate's in1/in2/in3 through all 8 combinations and holds each stable for a programmable settle time, modelling the slow response of the gate.
- Samples the gate output per combination, assembles an 8-bit truth-table byte and compares it against the expected rule.
- Sits directly upstream of the gate (feeds its inputs) and downstream of it (consumes its output).

---
 rtl/tt_sweep_pkg.sv | 24 ++
 rtl/tt_settle_timer.sv | 34 +++
 rtl/tt_sweep_checker.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
package tt_sweep_pkg;

  localparam int IDX_W      = 3;
  localparam int NUM_COMBOS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Two-of-three vote used to reject a single bad sample.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Rule ordering: combination 000 lands in the MSB of the table byte.
  function automatic logic [IDX_W-1:0] bit_pos(input logic [IDX_W-1:0] idx);
    return IDX_W'(NUM_COMBOS - 1) - idx;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle down-counter: load, decrement, terminal-count flag on the last
// settle cycle (count == 1).
module tt_settle_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: load wins over decrement; never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/tt_sweep_checker.sv
// Truth-table sweep checker: steps a 3-input gate through all 8 input
// combinations, samples its output after a settle time and compares the
// assembled byte against EXPECTED.
// Optional build macro: TT_SWEEP_MAJORITY_EN (3-sample majority vote per
// combination instead of a single sample).
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; inputs and results hold
// SETTLE | gate inputs held stable while the settle timer runs down
// SAMPLE | capture dut_out into the table bit for the current combination
// DONE   | one-cycle done pulse; pass already reflects the full table
module tt_sweep_checker
  import tt_sweep_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [7:0] EXPECTED      = 8'h5B,
  parameter int         CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] table_out
);

  // A zero settle time would make SAMPLE see inputs from the same edge.
  localparam int               S_EFF  = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam logic [CNT_W-1:0] S_LOAD = CNT_W'(S_EFF);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       table_q, table_d;
  logic             pass_q, pass_d;
  logic             tmr_load, tmr_dec, tmr_tc;
  logic             smp_fire, smp_bit;

`ifdef TT_SWEEP_MAJORITY_EN
  logic [1:0] smp_q, smp_d;
  logic       s0_q, s0_d, s1_q, s1_d;
`endif

  tt_settle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (S_LOAD),
    .dec      (tmr_dec),
    .tc       (tmr_tc)
  );

  // Sample capture: decides when the table bit is committed and its value.
  always_comb begin
    smp_fire = 1'b0;
    smp_bit  = dut_out;
`ifdef TT_SWEEP_MAJORITY_EN
    smp_d = smp_q;
    s0_d  = s0_q;
    s1_d  = s1_q;
    if (state_q == SAMPLE) begin
      case (smp_q)
        2'd0: begin
          s0_d  = dut_out;
          smp_d = 2'd1;
        end
        2'd1: begin
          s1_d  = dut_out;
          smp_d = 2'd2;
        end
        default: begin
          smp_d    = 2'd0;
          smp_fire = 1'b1;
          smp_bit  = maj3(s0_q, s1_q, dut_out);
        end
      endcase
    end else begin
      smp_d = 2'd0;
    end
`else
    smp_fire = (state_q == SAMPLE);
`endif
  end

  // Next-state and datapath updates for the sweep sequence.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    table_d  = table_q;
    pass_d   = pass_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          table_d  = 8'h00;
          pass_d   = 1'b0;
          idx_d    = '0;
          tmr_load = 1'b1;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        tmr_dec = 1'b1;
        if (tmr_tc) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (smp_fire) begin
          table_d[bit_pos(idx_q)] = smp_bit;
          if (idx_q == IDX_W'(NUM_COMBOS - 1)) begin
            // Registered here so pass is already valid during DONE.
            pass_d  = (table_d == EXPECTED);
            state_d = DONE;
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            tmr_load = 1'b1;
            state_d  = SETTLE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any sweep in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      table_q <= 8'h00;
      pass_q  <= 1'b0;
`ifdef TT_SWEEP_MAJORITY_EN
      smp_q   <= 2'd0;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      table_q <= table_d;
      pass_q  <= pass_d;
`ifdef TT_SWEEP_MAJORITY_EN
      smp_q   <= smp_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
`endif
    end
  end

  // Gate inputs come straight from the idx register, so they are glitch-free.
  assign {in1, in2, in3} = idx_q;
  assign busy            = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done            = (state_q == DONE);
  assign pass            = pass_q;
  assign table_out       = table_q;

endmodule
